// File: rtl/game_pkg.sv
// Shared game-layer types and raster constants.
// Used by damage, health-bar and sprite blocks.
package game_pkg;

  typedef enum logic [1:0] {
    ALIVE,
    INVULN,
    DEAD
  } player_state_t;

  localparam int H_ACTIVE = 1280;
  localparam int V_ACTIVE = 720;
  localparam int COLOR_W  = 12;

endpackage

// File: rtl/collision_detect.sv
// Per-pixel sprite overlap, gated to the active raster region.
// Also usable for enemy-projectile overlap checks.
module collision_detect #(
  parameter int H_ACTIVE = game_pkg::H_ACTIVE,
  parameter int V_ACTIVE = game_pkg::V_ACTIVE
) (
  input  logic [10:0]                  hcount_in,
  input  logic [9:0]                   vcount_in,
  input  logic [game_pkg::COLOR_W-1:0] player_pixel_in,
  input  logic [game_pkg::COLOR_W-1:0] hazard_pixel_in,
  input  logic                         en_in,
  output logic                         hit_px_out
);
  import game_pkg::*;

  localparam logic [10:0] H_LIM = 11'(H_ACTIVE);
  localparam logic [9:0]  V_LIM = 10'(V_ACTIVE);

  logic w_active;
  logic w_overlap;

  assign w_active   = (hcount_in < H_LIM) && (vcount_in < V_LIM);
  assign w_overlap  = (|player_pixel_in) && (|hazard_pixel_in);
  assign hit_px_out = en_in && w_active && w_overlap;

endmodule

// File: rtl/damage_controller.sv
// Turns sprite overlap into frame-aligned damage events and owns
// health, the post-hit invulnerability window and game-over.
module damage_controller #(
  parameter int MAX_HEALTH    = 12,
  parameter int INVULN_FRAMES = 60,
  parameter int BLINK_FRAMES  = 4,
  parameter int H_ACTIVE      = game_pkg::H_ACTIVE,
  parameter int V_ACTIVE      = game_pkg::V_ACTIVE
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [10:0]                   hcount_in,
  input  logic [9:0]                    vcount_in,
  input  logic [game_pkg::COLOR_W-1:0]  player_pixel_in,
  input  logic [game_pkg::COLOR_W-1:0]  hazard_pixel_in,
  output logic                          damage_out,
  output logic [$clog2(MAX_HEALTH+1)-1:0] health_out,
  output logic                          invuln_out,
  output logic                          blink_out,
  output logic                          game_over_out
);
  import game_pkg::*;

  localparam int HW = $clog2(MAX_HEALTH+1);
  localparam int IW = $clog2(INVULN_FRAMES+1);
  localparam int BW = $clog2(BLINK_FRAMES+1);

  player_state_t r_state, w_state_n;
  logic [HW-1:0] r_health, w_health_n;
  logic [IW-1:0] r_inv_cnt, w_inv_cnt_n;
  logic [BW-1:0] r_blink_cnt, w_blink_cnt_n;
  logic          r_blink, w_blink_n;
  logic          r_hit_seen, w_hit_seen_n;
  logic          w_frame_start;
  logic          w_alive;
  logic          w_hit_px;

  assign w_frame_start = (hcount_in == 11'd0) && (vcount_in == 10'd0);
  assign w_alive       = (r_state == ALIVE);

  collision_detect #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE)
  ) u_coll (
    .hcount_in       (hcount_in),
    .vcount_in       (vcount_in),
    .player_pixel_in (player_pixel_in),
    .hazard_pixel_in (hazard_pixel_in),
    .en_in           (w_alive),
    .hit_px_out      (w_hit_px)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ALIVE;
      r_health    <= HW'(MAX_HEALTH);
      r_inv_cnt   <= '0;
      r_blink_cnt <= '0;
      r_blink     <= 1'b1;
      r_hit_seen  <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_health    <= w_health_n;
      r_inv_cnt   <= w_inv_cnt_n;
      r_blink_cnt <= w_blink_cnt_n;
      r_blink     <= w_blink_n;
      r_hit_seen  <= w_hit_seen_n;
    end
  end

  always_comb begin
    w_state_n     = r_state;
    w_health_n    = r_health;
    w_inv_cnt_n   = r_inv_cnt;
    w_blink_cnt_n = r_blink_cnt;
    w_blink_n     = r_blink;
    // frame-start pixel opens the new frame's hit window
    w_hit_seen_n  = w_frame_start ? w_hit_px
                                  : (r_hit_seen | w_hit_px);
    damage_out    = w_frame_start && r_hit_seen && w_alive;

    if (w_frame_start) begin
      unique case (r_state)
        ALIVE: begin
          if (damage_out) begin
            if (r_health > HW'(1)) begin
              w_state_n     = INVULN;
              w_health_n    = r_health - HW'(1);
              w_inv_cnt_n   = IW'(INVULN_FRAMES);
              w_blink_cnt_n = '0;
              w_blink_n     = 1'b0;
            end else begin
              w_state_n  = DEAD;
              w_health_n = '0;
            end
          end
        end
        INVULN: begin
          if (r_inv_cnt == IW'(1)) begin
            w_state_n   = ALIVE;
            w_inv_cnt_n = '0;
            w_blink_n   = 1'b1;
          end else begin
            w_inv_cnt_n = r_inv_cnt - IW'(1);
            if (r_blink_cnt == BW'(BLINK_FRAMES-1)) begin
              w_blink_cnt_n = '0;
              w_blink_n     = ~r_blink;
            end else begin
              w_blink_cnt_n = r_blink_cnt + BW'(1);
            end
          end
        end
        DEAD: begin
          w_health_n = '0;
        end
        default: begin
          w_state_n = ALIVE;
        end
      endcase
    end
  end

  assign health_out    = r_health;
  assign invuln_out    = (r_state == INVULN);
  assign game_over_out = (r_state == DEAD);
  assign blink_out     = (r_state == INVULN) ? r_blink : 1'b1;

endmodule
